mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single line-granular memory bus between two cache requesters.
//  Typical pairing: instruction cache and data cache.
//  Grants one whole line transaction (read fill or write-back) at a time, round-robin.
//  Sequences the bus cmd/beat/response protocol and watchdogs memory responses.
//  Requester-side ports are unidirectional; the top level wraps mem_*_o/_oe/_i onto the
//  inout bus with bufif1.
// PARAMETERS
//  CACHE_LINE_SIZE  16    line size in bytes
//  ADDR_W           14    line address width
//  DATA_W           16    bus beat width; BEATS = CACHE_LINE_SIZE*8/DATA_W (=8)
//  TIMEOUT_CYCLES   255   max wait for memory response before abort (>=1)
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  reset        in   1       asynchronous, active-low reset
//  rqN_cmd      in   2       N=0,1: 0 none, 2 read line, 3 write line; 1 is illegal and ignored
//  rqN_addr     in   ADDR_W  line address; held by requester until rqN_gnt
//  rqN_wdata    in   DATA_W  write beat; see write timing
//  rqN_gnt      out  1       1-cycle pulse: request accepted
//  rqN_rdata    out  DATA_W  read beat
//  rqN_rvalid   out  1       rqN_rdata valid this cycle
//  rqN_done     out  1       1-cycle pulse: transaction finished (or aborted)
//  mem_addr     out  ADDR_W  bus line address
//  mem_ctrl_o   out  2       bus ctrl drive value
//  mem_ctrl_oe  out  1       bus ctrl drive enable
//  mem_ctrl_i   in   2       bus ctrl sampled; 1 = memory response
//  mem_data_o   out  DATA_W  bus data drive value
//  mem_data_oe  out  1       bus data drive enable
//  mem_data_i   in   DATA_W  bus data sampled
//  busy         out  1       state != IDLE
//  timeout_err  out  1       sticky; set on any watchdog abort
// BEHAVIOUR
//  Reset: every output 0, including both oe, mem_addr and timeout_err; state=IDLE; last=1.
//  Reset is asserted asynchronously mid-transfer: bus is released at once, transfer dropped,
//   no done pulse.
//  Cycle k means the cycle following posedge k.
//  Arbitration (IDLE only): requests are sampled at posedge P0.
//   Single valid requester wins; both valid -> winner = ~last; last <= winner.
//   Winner's rqN_gnt=1 in cycle 1; owner, cmd and addr are latched; loser keeps waiting.
//   cmd changes outside IDLE are ignored.
//  WRITE (cmd 3):
//   WR_BEATS, cycles 2..BEATS+1: mem_ctrl_o=3, mem_ctrl_oe=1, mem_data_oe=1.
//    mem_addr=latched addr. mem_data_o = owner's rqN_wdata, combinational pass-through.
//    Requester presents beat k in cycle 2+k.
//   WR_WAIT: oe's 0; wait mem_ctrl_i==1 -> rqN_done pulse next cycle; state -> IDLE.
//  READ (cmd 2):
//   RD_CMD, cycle 2: mem_ctrl_o=2, mem_ctrl_oe=1, mem_addr driven.
//   RD_WAIT: oe 0. First posedge with mem_ctrl_i==1 captures beat 0.
//    Beats 1..BEATS-1 are captured on the following consecutive posedges.
//   Each captured beat is registered: rqN_rdata/rqN_rvalid one cycle later.
//   rqN_done pulses the cycle after the last rvalid; state -> IDLE.
//  Watchdog: counter runs in WR_WAIT/RD_WAIT until the first response.
//   TIMEOUT_CYCLES elapse with no response -> timeout_err<=1 (cleared only by reset).
//   Owner gets done with no rvalid; state -> IDLE.
//  Turnaround: at least one IDLE cycle between transactions; mem_addr holds its last value.
//  Non-owner outputs stay 0 throughout; only one requester's gnt/rvalid/done ever high.
//  Beat counter is 3 bits for BEATS=8 and wraps only on exit.
//  The watchdog counter saturates.
// STRUCTURE
//  Package mem_bus_pkg:
//   MEM_NONE=0, MEM_RESP=1, MEM_READ=2, MEM_WRITE=3 ctrl codes.
//   arb_state_t {IDLE, WR_BEATS, WR_WAIT, RD_CMD, RD_WAIT}.
//  Sub-module rr_arbiter2: 2-way round-robin picker holding `last`.
//   Inputs: req[1:0], take. Outputs: grant[1:0].
// TESTING
//  Reset mid-write: reset low in WR_BEATS beat 3.
//   -> mem_*_oe=0 immediately, no done; after release, busy=0.
//  rq0 read addr 14'h0123; memory responds 5 cycles after RD_CMD with beats 16'hA000..A007.
//   -> gnt0 in cycle 1; mem_ctrl_o=2 in cycle 2.
//   -> 8 consecutive rvalid0 with A000..A007; done0 once.
//  rq1 write addr 14'h3FFF, wdata 16'hB000+k.
//   -> mem_data_o sequence B000..B007 with ctrl 3.
//   -> done1 one cycle after mem_ctrl_i==1.
//  Both request in the same cycle from reset.
//   -> rq0 served first, then rq1; repeated dual request alternates 0,1,0,1.
//  Memory never responds to a read.
//   -> after TIMEOUT_CYCLES, timeout_err=1, done0 with no rvalid.
//   -> next request still served.
//  rq0_cmd=1 held for 20 cycles -> no gnt, busy stays 0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the line-granular memory bus and its port arbiter.
//   MEM_*        : bus ctrl codes (driven on mem_ctrl_o, sampled on mem_ctrl_i)
//   arb_state_t  : arbiter sequencer states
//   cmd_valid()  : true for the requester commands that start a line transaction
package mem_bus_pkg;

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_RESP  = 2'd1;
    localparam logic [1:0] MEM_READ  = 2'd2;
    localparam logic [1:0] MEM_WRITE = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BEATS = 3'd1,
        WR_WAIT  = 3'd2,
        RD_CMD   = 3'd3,
        RD_WAIT  = 3'd4
    } arb_state_t;

    // Requester cmd 1 collides with the memory response code and is never a request.
    function automatic logic cmd_valid(input logic [1:0] cmd);
        return (cmd == MEM_READ) || (cmd == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker.
//   clk, reset : clock, asynchronous active-low reset
//   req[1:0]   : requester N is asking this cycle
//   take       : the caller accepts the current grant; the winner becomes `last`
//   grant[1:0] : one-hot pick (combinational), 0 when nobody asks
// After reset last=1, so a simultaneous first request goes to requester 0.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (take && (grant != 2'b00)) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-granular memory bus between two cache requesters,
// one whole line transaction (read fill or write-back) at a time, round-robin.
//   clk, reset                 : clock, asynchronous active-low reset
//   rqN_cmd/addr/wdata         : requester N command (0 none, 2 read, 3 write), line address,
//                                write beat (passed straight through to mem_data_o)
//   rqN_gnt/rdata/rvalid/done  : accept pulse, read beat + valid, end-of-transaction pulse
//   mem_addr, mem_ctrl_*,
//   mem_data_*                 : bus side; *_o/*_oe are wrapped onto the inout bus above
//   busy                       : sequencer not in IDLE
//   timeout_err                : sticky, set when the response watchdog aborts a transfer
//
// Handshake: a requester's cmd (2 or 3) is its valid; it holds cmd/addr until rqN_gnt,
// which is the one-cycle accept. The request is sampled at the edge closing cycle 0,
// gnt shows in cycle 1 and the bus phase starts in cycle 2. Completion is rqN_done.
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = 16,
    parameter int ADDR_W          = 14,
    parameter int DATA_W          = 16,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        rq0_cmd,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_gnt,
    output logic [DATA_W-1:0] rq0_rdata,
    output logic              rq0_rvalid,
    output logic              rq0_done,
    input  logic [1:0]        rq1_cmd,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_gnt,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              rq1_rvalid,
    output logic              rq1_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_ctrl_o,
    output logic              mem_ctrl_oe,
    input  logic [1:0]        mem_ctrl_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_data_oe,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              busy,
    output logic              timeout_err
);

    localparam int BEATS  = CACHE_LINE_SIZE * 8 / DATA_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t state_q, state_d;

    logic              start_q;      // grant issued, bus phase begins next edge
    logic              owner_q;      // 0: rq0 owns the bus, 1: rq1
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              gnt_q;
    logic              done_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              timeout_err_q;
    logic [BEAT_W-1:0] beat_q;
    logic [WD_W-1:0]   wd_q;
    logic              resp_seen_q;  // read burst in progress
    logic              rd_last_q;    // last read beat captured, done goes out next edge

    logic [1:0] req;
    logic [1:0] grant;
    logic       take;
    logic       launch;
    logic       capture;
    logic       finish;
    logic       abort;
    logic       leaving;
    logic       resp;
    logic       wd_expired;
    logic       wd_run;

    assign req        = {cmd_valid(rq1_cmd), cmd_valid(rq0_cmd)};
    assign take       = (state_q == IDLE) && !start_q && (req != 2'b00);
    assign resp       = (mem_ctrl_i == MEM_RESP);
    assign wd_expired = (wd_q == WD_LIMIT);
    assign wd_run     = (state_q == WR_WAIT) || ((state_q == RD_WAIT) && !resp_seen_q);
    assign leaving    = (state_q != IDLE) && (state_d == IDLE);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .take  (take),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus drive. The bus is only driven in WR_BEATS and RD_CMD, so an
    // asynchronous reset drops both enables in the same instant the state clears.
    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        capture     = 1'b0;
        finish      = 1'b0;
        abort       = 1'b0;
        mem_ctrl_o  = MEM_NONE;
        mem_ctrl_oe = 1'b0;
        mem_data_o  = '0;
        mem_data_oe = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    launch  = 1'b1;
                    state_d = (cmd_q == MEM_WRITE) ? WR_BEATS : RD_CMD;
                end
            end
            WR_BEATS: begin
                mem_ctrl_o  = MEM_WRITE;
                mem_ctrl_oe = 1'b1;
                mem_data_oe = 1'b1;
                mem_data_o  = owner_q ? rq1_wdata : rq0_wdata;
                if (beat_q == LAST_BEAT) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (resp) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_CMD: begin
                mem_ctrl_o  = MEM_READ;
                mem_ctrl_oe = 1'b1;
                state_d     = RD_WAIT;
            end
            RD_WAIT: begin
                // Only beat 0 is marked by a response code; the rest follow back to back.
                if (rd_last_q) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (resp_seen_q || resp) begin
                    capture = 1'b1;
                end else if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q       <= 1'b0;
            owner_q       <= 1'b0;
            cmd_q         <= MEM_NONE;
            addr_q        <= '0;
            mem_addr_q    <= '0;
            gnt_q         <= 1'b0;
            done_q        <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            timeout_err_q <= 1'b0;
            beat_q        <= '0;
            wd_q          <= '0;
            resp_seen_q   <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            start_q  <= take;
            gnt_q    <= take;
            done_q   <= finish || abort;
            rvalid_q <= capture;

            if (take) begin
                owner_q <= grant[1];
                cmd_q   <= grant[1] ? rq1_cmd : rq0_cmd;
                addr_q  <= grant[1] ? rq1_addr : rq0_addr;
            end

            // mem_addr only moves when a bus phase starts, so it holds through turnaround.
            if (launch) begin
                mem_addr_q <= addr_q;
            end

            if (capture) begin
                rdata_q <= mem_data_i;
            end

            if (abort) begin
                timeout_err_q <= 1'b1;
            end

            if (state_q == WR_BEATS) begin
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
            end else if (leaving) begin
                beat_q <= '0;
            end else if (capture && (beat_q != LAST_BEAT)) begin
                beat_q <= beat_q + 1'b1;
            end

            if (leaving) begin
                resp_seen_q <= 1'b0;
                rd_last_q   <= 1'b0;
            end else if (capture) begin
                resp_seen_q <= 1'b1;
                if (beat_q == LAST_BEAT) begin
                    rd_last_q <= 1'b1;
                end
            end

            if (launch) begin
                wd_q <= '0;
            end else if (wd_run && !resp && !wd_expired) begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    assign rq0_gnt     = gnt_q && !owner_q;
    assign rq1_gnt     = gnt_q && owner_q;
    assign rq0_done    = done_q && !owner_q;
    assign rq1_done    = done_q && owner_q;
    assign rq0_rvalid  = rvalid_q && !owner_q;
    assign rq1_rvalid  = rvalid_q && owner_q;
    assign rq0_rdata   = rq0_rvalid ? rdata_q : '0;
    assign rq1_rdata   = rq1_rvalid ? rdata_q : '0;
    assign mem_addr    = mem_addr_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with default parameters (8 beats, timeout 255).
// Cycle k is the cycle after posedge k; inputs are driven 1 time unit after the edge and
// outputs are examined 2 units after it (registered outputs already settled).
module tb_mem_port_arbiter;
    import mem_bus_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  rq0_cmd, rq1_cmd;
    logic [13:0] rq0_addr, rq1_addr;
    logic [15:0] rq0_wdata, rq1_wdata;
    logic        rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, rq0_done, rq1_done;
    logic [15:0] rq0_rdata, rq1_rdata;
    logic [13:0] mem_addr;
    logic [1:0]  mem_ctrl_o, mem_ctrl_i;
    logic        mem_ctrl_oe, mem_data_oe;
    logic [15:0] mem_data_o, mem_data_i;
    logic        busy, timeout_err;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];   // {owner, beat} expected on rvalid
    logic [16:0] exp_v;

    mem_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .rq0_cmd     (rq0_cmd),
        .rq0_addr    (rq0_addr),
        .rq0_wdata   (rq0_wdata),
        .rq0_gnt     (rq0_gnt),
        .rq0_rdata   (rq0_rdata),
        .rq0_rvalid  (rq0_rvalid),
        .rq0_done    (rq0_done),
        .rq1_cmd     (rq1_cmd),
        .rq1_addr    (rq1_addr),
        .rq1_wdata   (rq1_wdata),
        .rq1_gnt     (rq1_gnt),
        .rq1_rdata   (rq1_rdata),
        .rq1_rvalid  (rq1_rvalid),
        .rq1_done    (rq1_done),
        .mem_addr    (mem_addr),
        .mem_ctrl_o  (mem_ctrl_o),
        .mem_ctrl_oe (mem_ctrl_oe),
        .mem_ctrl_i  (mem_ctrl_i),
        .mem_data_o  (mem_data_o),
        .mem_data_oe (mem_data_oe),
        .mem_data_i  (mem_data_i),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic gnt_of(input int rq);
        return (rq != 0) ? rq1_gnt : rq0_gnt;
    endfunction

    function automatic logic done_of(input int rq);
        return (rq != 0) ? rq1_done : rq0_done;
    endfunction

    function automatic logic rvalid_of(input int rq);
        return (rq != 0) ? rq1_rvalid : rq0_rvalid;
    endfunction

    task automatic set_cmd(input int rq, input logic [1:0] cmd, input logic [13:0] addr);
        if (rq != 0) begin
            rq1_cmd = cmd;
            rq1_addr = addr;
        end else begin
            rq0_cmd = cmd;
            rq0_addr = addr;
        end
    endtask

    // Owner gets the real beat, the other requester gets noise the DUT must not select.
    task automatic drive_wdata(input int rq, input logic [15:0] v);
        if (rq != 0) begin
            rq1_wdata = v;
            rq0_wdata = 16'($urandom_range(0, 65535));
        end else begin
            rq0_wdata = v;
            rq1_wdata = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic idle_inputs();
        rq0_cmd = MEM_NONE;
        rq1_cmd = MEM_NONE;
        rq0_addr = '0;
        rq1_addr = '0;
        rq0_wdata = '0;
        rq1_wdata = '0;
        mem_ctrl_i = MEM_NONE;
        mem_data_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        cyc();
    endtask

    // Full read line: memory answers resp_delay cycles after RD_CMD (cycle 2).
    task automatic read_line(input int rq, input logic [13:0] addr, input logic [15:0] base,
                             input int resp_delay, input string tag);
        int r;
        int ndone;
        int done_at;
        int nrv;
        int rv_first;
        r = 2 + resp_delay;
        ndone = 0;
        done_at = -1;
        nrv = 0;
        rv_first = -1;
        for (int k = 0; k < 8; k++) exp_q.push_back({1'(rq), base + 16'(k)});
        cyc();
        set_cmd(rq, MEM_READ, addr);
        for (int c = 1; c <= r + 10; c++) begin
            cyc();
            if (c == 2) set_cmd(rq, MEM_NONE, '0);
            mem_ctrl_i = (c == r) ? MEM_RESP : MEM_NONE;
            mem_data_i = (c >= r && c <= r + 7) ? base + 16'(c - r) : 16'h0000;
            #1;
            if (c == 1) check({tag, "_gnt_c1"}, 32'(gnt_of(rq)), 32'd1);
            if (c == 2) begin
                check({tag, "_ctrl_c2"}, 32'(mem_ctrl_o), 32'(MEM_READ));
                check({tag, "_ctrl_oe_c2"}, 32'(mem_ctrl_oe), 32'd1);
                check({tag, "_addr_c2"}, 32'(mem_addr), 32'(addr));
            end
            if (c == 3) check({tag, "_ctrl_oe_c3"}, 32'(mem_ctrl_oe), 32'd0);
            if (rvalid_of(rq)) begin
                nrv++;
                if (rv_first < 0) rv_first = c;
            end
            if (done_of(rq)) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
        end
        check({tag, "_rvalid_count"}, 32'(nrv), 32'd8);
        check({tag, "_rvalid_first"}, 32'(rv_first), 32'(r + 1));
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_at), 32'(r + 9));
        check({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    // Full write line: memory answers resp_delay cycles after entering WR_WAIT (cycle 10).
    task automatic write_line(input int rq, input logic [13:0] addr, input logic [15:0] base,
                              input int resp_delay, input string tag);
        int w;
        int ndone;
        int done_at;
        w = 10 + resp_delay;
        ndone = 0;
        done_at = -1;
        cyc();
        set_cmd(rq, MEM_WRITE, addr);
        for (int c = 1; c <= w + 2; c++) begin
            cyc();
            if (c == 2) set_cmd(rq, MEM_NONE, '0);
            if (c >= 2 && c <= 9) drive_wdata(rq, base + 16'(c - 2));
            mem_ctrl_i = (c == w) ? MEM_RESP : MEM_NONE;
            #1;
            if (c == 1) check({tag, "_gnt_c1"}, 32'(gnt_of(rq)), 32'd1);
            if (c >= 2 && c <= 9) begin
                check({tag, "_ctrl"}, 32'(mem_ctrl_o), 32'(MEM_WRITE));
                check({tag, "_ctrl_oe"}, 32'(mem_ctrl_oe), 32'd1);
                check({tag, "_data_oe"}, 32'(mem_data_oe), 32'd1);
                check({tag, "_data"}, 32'(mem_data_o), 32'(base + 16'(c - 2)));
                check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
            end
            if (c == 10) begin
                check({tag, "_wait_ctrl_oe"}, 32'(mem_ctrl_oe), 32'd0);
                check({tag, "_wait_data_oe"}, 32'(mem_data_oe), 32'd0);
            end
            if (done_of(rq)) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
        end
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_at), 32'(w + 1));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            check("one_owner_strobes",
                  {29'd0, rq0_gnt & rq1_gnt, rq0_rvalid & rq1_rvalid, rq0_done & rq1_done}, 32'd0);
            if (rq0_rvalid || rq1_rvalid) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL rvalid_unexpected observed=%0h expected=no_rvalid",
                           {rq1_rvalid, rq0_rdata | rq1_rdata});
                end
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check("rdata", {15'd0, rq1_rvalid, rq0_rdata | rq1_rdata}, {15'd0, exp_v});
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int gord[4];
        int ng;
        int done_at;
        int terr_at;
        int nrv;

        idle_inputs();
        reset = 1'b0;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_ctrl_oe", 32'(mem_ctrl_oe), 32'd0);
        check("rst_data_oe", 32'(mem_data_oe), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_ctrl_o", 32'(mem_ctrl_o), 32'd0);
        check("rst_mem_data_o", 32'(mem_data_o), 32'd0);
        check("rst_rq_outs",
              {26'd0, rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, rq0_done, rq1_done}, 32'd0);
        check("rst_rdata", {rq0_rdata, rq1_rdata}, 32'd0);
        #1;
        reset = 1'b1;
        cyc();

        // Illegal cmd 1 held for 20 cycles.
        rq0_cmd = 2'd1;
        rq0_addr = 14'h0777;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            #1;
            if (rq0_gnt || rq1_gnt || busy) n++;
        end
        check("illegal_cmd_activity", 32'(n), 32'd0);
        rq0_cmd = MEM_NONE;
        cyc();

        // rq0 read, memory answers 5 cycles after RD_CMD.
        read_line(0, 14'h0123, 16'hA000, 5, "rd0");
        cyc();

        // rq1 write-back, response 2 cycles into WR_WAIT.
        write_line(1, 14'h3FFF, 16'hB000, 2, "wr1");
        cyc();

        // Asynchronous reset in the middle of a write (beat 3, cycle 5).
        cyc();
        set_cmd(0, MEM_WRITE, 14'h0055);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 2) set_cmd(0, MEM_NONE, '0);
            if (c >= 2) drive_wdata(0, 16'hC000 + 16'(c - 2));
            #1;
            if (c == 1) check("rstmid_gnt_c1", 32'(rq0_gnt), 32'd1);
        end
        check("rstmid_data_beat3", 32'(mem_data_o), 32'h0000_C003);
        check("rstmid_oe_before", 32'(mem_data_oe), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rstmid_ctrl_oe_now", 32'(mem_ctrl_oe), 32'd0);
        check("rstmid_data_oe_now", 32'(mem_data_oe), 32'd0);
        check("rstmid_busy_now", 32'(busy), 32'd0);
        n = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            if (rq0_done || rq1_done) n++;
        end
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            #1;
            if (rq0_done || rq1_done || busy) n++;
        end
        check("rstmid_no_done_no_busy", 32'(n), 32'd0);
        check("rstmid_busy_after", 32'(busy), 32'd0);

        // Both request from reset and keep requesting: order must be 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) gord[i] = -1;
        ng = 0;
        rq0_cmd = MEM_WRITE;
        rq0_addr = 14'h0010;
        rq1_cmd = MEM_WRITE;
        rq1_addr = 14'h0020;
        mem_ctrl_i = MEM_RESP;
        for (int c = 0; c < 100 && ng < 4; c++) begin
            cyc();
            #1;
            if (rq0_gnt) begin
                gord[ng] = 0;
                ng++;
            end else if (rq1_gnt) begin
                gord[ng] = 1;
                ng++;
            end
        end
        rq0_cmd = MEM_NONE;
        rq1_cmd = MEM_NONE;
        check("dual_grant_count", 32'(ng), 32'd4);
        check("dual_order0", 32'(gord[0]), 32'd0);
        check("dual_order1", 32'(gord[1]), 32'd1);
        check("dual_order2", 32'(gord[2]), 32'd0);
        check("dual_order3", 32'(gord[3]), 32'd1);
        n = 0;
        for (int c = 0; c < 40 && (busy || n == 0); c++) begin
            cyc();
            #1;
            n++;
        end
        check("dual_idle_after", 32'(busy), 32'd0);
        mem_ctrl_i = MEM_NONE;
        cyc();

        // Read that memory never answers.
        cyc();
        set_cmd(0, MEM_READ, 14'h0042);
        done_at = -1;
        terr_at = -1;
        n = 0;
        nrv = 0;
        for (int c = 1; c <= 262; c++) begin
            cyc();
            if (c == 2) set_cmd(0, MEM_NONE, '0);
            #1;
            if (c == 1) check("to_gnt_c1", 32'(rq0_gnt), 32'd1);
            if (rq0_rvalid) nrv++;
            if (rq0_done) begin
                n++;
                if (done_at < 0) done_at = c;
            end
            if (timeout_err && terr_at < 0) terr_at = c;
        end
        check("to_done_cycle", 32'(done_at), 32'd258);
        check("to_err_cycle", 32'(terr_at), 32'd258);
        check("to_done_count", 32'(n), 32'd1);
        check("to_no_rvalid", 32'(nrv), 32'd0);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        check("to_busy_after", 32'(busy), 32'd0);

        // Next request is still served; the error flag stays set.
        read_line(1, 14'h1ABC, 16'h5100, 2, "rd1_after_to");
        check("to_err_still_set", 32'(timeout_err), 32'd1);

        // ---------------- final report ----------------
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
